// File: rtl/window_gen_mc.sv
// Streaming multi-channel KxK sliding-window generator with line buffers, stride and SAME/VALID padding.
// Pixels enter raster order over valid/ready; one flattened CH*K*K window leaves per output position.
module window_gen_mc #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNELS    = 1,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int MODE        = 0
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   frame_start,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                         in_pixel,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_window,
    output logic [15:0]                                            out_x,
    output logic [15:0]                                            out_y,
    output logic                                                   frame_done
);
    localparam int K    = KERNEL_SIZE;
    localparam int PW   = CHANNELS * DATA_WIDTH;
    localparam int N    = CHANNELS * K * K;
    localparam int P    = (MODE == 0) ? (K - 1) / 2 : 0;
    localparam int OW   = (MODE == 0) ? (IMG_WIDTH + STRIDE - 1) / STRIDE : (IMG_WIDTH - K) / STRIDE + 1;
    localparam int OH   = (MODE == 0) ? (IMG_HEIGHT + STRIDE - 1) / STRIDE : (IMG_HEIGHT - K) / STRIDE + 1;
    localparam int MAXD = (IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT;
    localparam int CW   = $clog2(MAXD + K + STRIDE) + 2;
    localparam int AW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int SW   = (K > 1) ? $clog2(K) : 1;
    localparam int OXW  = $clog2(OW + 1);
    localparam int OYW  = $clog2(OH + 1);

    typedef logic signed [CW-1:0] pos_t;
    localparam pos_t W_P    = pos_t'(IMG_WIDTH);
    localparam pos_t H_P    = pos_t'(IMG_HEIGHT);
    localparam pos_t K1_P   = pos_t'(K - 1);
    localparam pos_t S_P    = pos_t'(STRIDE);
    localparam pos_t ONE_P  = pos_t'(1);
    localparam pos_t ZERO_P = pos_t'(0);
    localparam pos_t ORG_P  = pos_t'(-P);
    localparam logic [SW-1:0] SLOT0  = SW'((K - P) % K);
    localparam logic [SW-1:0] SSTEP  = SW'(STRIDE % K);
    localparam logic [SW-1:0] SLOT_M = SW'(K - 1);
    localparam logic [SW:0]   K_SL   = (SW + 1)'(K);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   line_mem [K][IMG_WIDTH];
    pos_t            in_x, in_y;
    logic [SW-1:0]   wr_slot;
    pos_t            base_x, base_y;
    logic [SW-1:0]   top_slot;
    logic [OXW-1:0]  ox;
    logic [OYW-1:0]  oy;
    logic            emit_done;

    pos_t            bx_end, by_end, rx, ry;
    logic            win_ready, pending, out_free, load, acc, last_px, fin;
    logic [SW:0]     step_sum;
    logic [SW-1:0]   slot_next;
    pos_t            tap_x, tap_y;
    logic [SW:0]     slot_sum;
    logic [N*DATA_WIDTH-1:0] window_n;

    // A window is complete once its bottom-right in-image tap has been written.
    always_comb begin
        bx_end    = base_x + K1_P;
        by_end    = base_y + K1_P;
        rx        = (bx_end > W_P - ONE_P) ? W_P - ONE_P : bx_end;
        ry        = (by_end > H_P - ONE_P) ? H_P - ONE_P : by_end;
        win_ready = (in_y > ry) || ((in_y == ry) && (in_x > rx));
        pending   = (state != IDLE) && !emit_done && win_ready;
        out_free  = !out_valid || out_ready;
        load      = pending && out_free && !frame_start;
        in_ready  = ((state == FILL) || (state == RUN)) && out_free && !pending && !frame_start;
        acc       = in_valid && in_ready;
        last_px   = (in_x == W_P - ONE_P) && (in_y == H_P - ONE_P);
        fin       = (state == FLUSH) && emit_done && out_free;
        step_sum  = {1'b0, top_slot} + {1'b0, SSTEP};
        slot_next = (step_sum >= K_SL) ? SW'(step_sum - K_SL) : SW'(step_sum);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_start) state_n = FILL;
            FILL:    if (acc && last_px) state_n = FLUSH;
                     else if (pending) state_n = RUN;
            RUN:     if (acc && last_px) state_n = FLUSH;
            FLUSH:   if (fin) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (frame_start) state_n = FILL;
    end

    // Taps outside the image read zero; row i of the window lives in slot (top_slot + i) mod K.
    always_comb begin
        window_n = '0;
        tap_x    = ZERO_P;
        tap_y    = ZERO_P;
        slot_sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    tap_y    = base_y + pos_t'(i);
                    tap_x    = base_x + pos_t'(j);
                    slot_sum = {1'b0, top_slot} + (SW + 1)'(i);
                    if (slot_sum >= K_SL) slot_sum = slot_sum - K_SL;
                    if (tap_x >= ZERO_P && tap_x < W_P && tap_y >= ZERO_P && tap_y < H_P)
                        window_n[(N - (c*K*K + i*K + j))*DATA_WIDTH-1 -: DATA_WIDTH] =
                            line_mem[slot_sum[SW-1:0]][tap_x[AW-1:0]][(c+1)*DATA_WIDTH-1 -: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc && !rst) line_mem[wr_slot][in_x[AW-1:0]] <= in_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_x       <= ZERO_P;
            in_y       <= ZERO_P;
            wr_slot    <= '0;
            base_x     <= ZERO_P;
            base_y     <= ZERO_P;
            top_slot   <= '0;
            ox         <= '0;
            oy         <= '0;
            emit_done  <= 1'b0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            frame_done <= fin;
            if (frame_start) begin
                in_x      <= ZERO_P;
                in_y      <= ZERO_P;
                wr_slot   <= '0;
                base_x    <= ORG_P;
                base_y    <= ORG_P;
                top_slot  <= SLOT0;
                ox        <= '0;
                oy        <= '0;
                emit_done <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (acc) begin
                    if (in_x == W_P - ONE_P) begin
                        in_x    <= ZERO_P;
                        in_y    <= in_y + ONE_P;
                        wr_slot <= (wr_slot == SLOT_M) ? '0 : wr_slot + 1'b1;
                    end else begin
                        in_x <= in_x + ONE_P;
                    end
                end
                if (load) begin
                    out_valid  <= 1'b1;
                    out_window <= window_n;
                    out_x      <= 16'(ox);
                    out_y      <= 16'(oy);
                    if (ox == OXW'(OW - 1)) begin
                        ox        <= '0;
                        base_x    <= ORG_P;
                        oy        <= oy + 1'b1;
                        base_y    <= base_y + S_P;
                        top_slot  <= slot_next;
                        emit_done <= (oy == OYW'(OH - 1));
                    end else begin
                        ox     <= ox + 1'b1;
                        base_x <= base_x + S_P;
                    end
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_window_gen_mc.sv
// Bench for window_gen_mc: five parameterisations share one stimulus/compare loop, selected by sel.
// Expected windows come from a tap-level model of the output grid and padding rules.
module tb_window_gen_mc;
    logic        clk = 1'b0;
    logic        rst, fs, iv, ordy;
    logic [31:0] ipix;
    int          sel;

    logic [4:0]  rdy_a, ov_a, fd_a;
    logic [15:0] ox_a [5];
    logic [15:0] oy_a [5];
    logic [143:0] w0, w1, w2;
    logic [287:0] w3;
    logic [399:0] w4;

    logic        rdy, ov, fd;
    logic [511:0] ow;
    logic [15:0] ox, oy;

    always #5 clk = ~clk;

    window_gen_mc #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .frame_start(fs && sel == 0), .in_valid(iv && sel == 0), .in_ready(rdy_a[0]),
        .in_pixel(ipix[15:0]), .out_valid(ov_a[0]), .out_ready(ordy && sel == 0), .out_window(w0),
        .out_x(ox_a[0]), .out_y(oy_a[0]), .frame_done(fd_a[0]));
    window_gen_mc #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .frame_start(fs && sel == 1), .in_valid(iv && sel == 1), .in_ready(rdy_a[1]),
        .in_pixel(ipix[15:0]), .out_valid(ov_a[1]), .out_ready(ordy && sel == 1), .out_window(w1),
        .out_x(ox_a[1]), .out_y(oy_a[1]), .frame_done(fd_a[1]));
    window_gen_mc #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(2), .MODE(0)) u2 (
        .clk(clk), .rst(rst), .frame_start(fs && sel == 2), .in_valid(iv && sel == 2), .in_ready(rdy_a[2]),
        .in_pixel(ipix[15:0]), .out_valid(ov_a[2]), .out_ready(ordy && sel == 2), .out_window(w2),
        .out_x(ox_a[2]), .out_y(oy_a[2]), .frame_done(fd_a[2]));
    window_gen_mc #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1), .MODE(0)) u3 (
        .clk(clk), .rst(rst), .frame_start(fs && sel == 3), .in_valid(iv && sel == 3), .in_ready(rdy_a[3]),
        .in_pixel(ipix), .out_valid(ov_a[3]), .out_ready(ordy && sel == 3), .out_window(w3),
        .out_x(ox_a[3]), .out_y(oy_a[3]), .frame_done(fd_a[3]));
    window_gen_mc #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_WIDTH(8), .IMG_HEIGHT(6), .KERNEL_SIZE(5), .STRIDE(1), .MODE(0)) u4 (
        .clk(clk), .rst(rst), .frame_start(fs && sel == 4), .in_valid(iv && sel == 4), .in_ready(rdy_a[4]),
        .in_pixel(ipix[15:0]), .out_valid(ov_a[4]), .out_ready(ordy && sel == 4), .out_window(w4),
        .out_x(ox_a[4]), .out_y(oy_a[4]), .frame_done(fd_a[4]));

    always_comb begin
        rdy = 1'b0; ov = 1'b0; fd = 1'b0; ox = '0; oy = '0; ow = '0;
        if (sel >= 0 && sel < 5) begin
            rdy = rdy_a[sel]; ov = ov_a[sel]; fd = fd_a[sel]; ox = ox_a[sel]; oy = oy_a[sel];
        end
        case (sel)
            0: ow = 512'(w0);
            1: ow = 512'(w1);
            2: ow = 512'(w2);
            3: ow = 512'(w3);
            4: ow = 512'(w4);
            default: ow = '0;
        endcase
    end

    int cfg_w [5] = '{4, 4, 4, 4, 8};
    int cfg_h [5] = '{4, 4, 4, 4, 6};
    int cfg_k [5] = '{3, 3, 3, 3, 5};
    int cfg_s [5] = '{1, 1, 2, 1, 1};
    int cfg_m [5] = '{0, 1, 0, 0, 0};
    int cfg_c [5] = '{1, 1, 1, 2, 1};
    int cW, cH, cK, cS, cM, cC;

    int errors = 0;
    int checks = 0;
    int nwin, fd_cnt, hold_cnt;
    int first_w [64];
    int last_w  [64];
    int cen [64];
    int wxs [64];
    int wys [64];
    int last_x, last_y;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int pix(input int c, input int x, input int y);
        return y * cW + x + 1 + 100 * c;
    endfunction
    function automatic int m_ow();
        return (cM != 0) ? (cW - cK) / cS + 1 : (cW + cS - 1) / cS;
    endfunction
    function automatic int m_oh();
        return (cM != 0) ? (cH - cK) / cS + 1 : (cH + cS - 1) / cS;
    endfunction
    // Value of flattened element e of window (wx, wy): locate the tap in image space, zero if off-image.
    function automatic int m_elem(input int wx, input int wy, input int e);
        int kk, c, i, j, p, tx, ty;
        kk = cK * cK;
        c  = e / kk;
        i  = (e % kk) / cK;
        j  = e % cK;
        p  = (cM != 0) ? 0 : (cK - 1) / 2;
        tx = wx * cS - p + j;
        ty = wy * cS - p + i;
        if (tx < 0 || ty < 0 || tx >= cW || ty >= cH) return 0;
        return pix(c, tx, ty);
    endfunction
    function automatic int get_elem(input logic [511:0] v, input int n, input int e);
        logic [511:0] t;
        t = v >> ((n - 1 - e) * 16);
        return int'(t[15:0]);
    endfunction

    task automatic run_frame(input int k, input int vpct, input int rpct, input int stall_at, input int abort_at);
        int px, cyc, total, npx, n, wx, wy, v;
        bit done, prev_hold, prev_last, aborted;
        logic [511:0] prev_w;
        logic [15:0]  prev_x, prev_y;
        sel = k;
        cW = cfg_w[k]; cH = cfg_h[k]; cK = cfg_k[k]; cS = cfg_s[k]; cM = cfg_m[k]; cC = cfg_c[k];
        total = m_ow() * m_oh();
        npx = cW * cH;
        n = cC * cK * cK;
        nwin = 0; fd_cnt = 0; hold_cnt = 0;
        px = 0; cyc = 0; done = 0; prev_hold = 0; prev_last = 0; aborted = 0;
        prev_w = '0; prev_x = '0; prev_y = '0;
        @(posedge clk); #1;
        fs = 1'b1; iv = 1'b0; ordy = 1'b0;
        @(posedge clk); #1;
        fs = 1'b0;
        while (!done) begin
            iv   = (px < npx) && ($urandom_range(99) < vpct);
            ipix = {16'(pix(1, px % cW, px / cW)), 16'(pix(0, px % cW, px / cW))};
            ordy = ($urandom_range(99) < rpct) && !(cyc >= stall_at && cyc < stall_at + 5);
            @(negedge clk);
            chk("frame_done_timing", int'(fd), int'(prev_last));
            if (fd) fd_cnt++;
            if (prev_hold) begin
                hold_cnt++;
                chk("hold_valid", int'(ov), 1);
                chk("hold_window", int'(ow == prev_w), 1);
                chk("hold_xy", int'(ox == prev_x && oy == prev_y), 1);
            end
            if (ov && !ordy) chk("in_ready_blocked", int'(rdy), 0);
            prev_last = 0;
            if (ov && ordy) begin
                if (nwin < total) begin
                    wx = nwin % m_ow();
                    wy = nwin / m_ow();
                    chk("out_x", int'(ox), wx);
                    chk("out_y", int'(oy), wy);
                    for (int e = 0; e < n; e++) begin
                        v = get_elem(ow, n, e);
                        chk($sformatf("win%0d_e%0d", nwin, e), v, m_elem(wx, wy, e));
                        if (nwin == 0) first_w[e] = v;
                        last_w[e] = v;
                    end
                    if (nwin < 64) begin
                        cen[nwin] = get_elem(ow, n, (cK * cK) / 2);
                        wxs[nwin] = int'(ox);
                        wys[nwin] = int'(oy);
                    end
                    last_x = int'(ox);
                    last_y = int'(oy);
                end else begin
                    chk("extra_window", nwin, total - 1);
                end
                nwin++;
                prev_last = (nwin == total);
            end
            prev_hold = ov && !ordy;
            prev_w = ow; prev_x = ox; prev_y = oy;
            if (iv && rdy) px++;
            cyc++;
            if (fd) done = 1;
            if (abort_at >= 0 && cyc == abort_at) begin
                done = 1;
                aborted = 1;
            end
            if (cyc > 5000) begin
                chk("timeout", cyc, 0);
                done = 1;
            end
            @(posedge clk); #1;
        end
        iv = 1'b0;
        ordy = 1'b0;
        if (!aborted) begin
            chk("window_count", nwin, total);
            chk("frame_done_count", fd_cnt, 1);
            chk("pixels_accepted", px, npx);
        end
    endtask

    int l1f [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    int l1l [9] = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    int l2f [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int l2l [9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    int l3x [4] = '{0, 1, 0, 1};
    int l3y [4] = '{0, 0, 1, 1};
    int l3c [4] = '{1, 3, 9, 11};

    task automatic pin_case1();
        chk("t1_count", nwin, 16);
        for (int i = 0; i < 9; i++) chk($sformatf("t1_first_e%0d", i), first_w[i], l1f[i]);
        for (int i = 0; i < 9; i++) chk($sformatf("t1_last_e%0d", i), last_w[i], l1l[i]);
        chk("t1_last_x", last_x, 3);
        chk("t1_last_y", last_y, 3);
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; iv = 1'b0; ordy = 1'b0; ipix = '0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(ov), 0);
        chk("rst_in_ready", int'(rdy), 0);
        chk("rst_out_xy", int'(ox) + int'(oy), 0);
        chk("rst_frame_done", int'(fd), 0);
        chk("rst_window_zero", int'(ow == '0), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        iv = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", int'(rdy), 0);
        @(posedge clk); #1;
        iv = 1'b0;

        run_frame(0, 100, 100, 100000, -1);
        pin_case1();

        run_frame(1, 100, 100, 100000, -1);
        chk("t2_count", nwin, 4);
        for (int i = 0; i < 9; i++) chk($sformatf("t2_first_e%0d", i), first_w[i], l2f[i]);
        for (int i = 0; i < 9; i++) chk($sformatf("t2_last_e%0d", i), last_w[i], l2l[i]);

        run_frame(2, 100, 100, 100000, -1);
        chk("t3_count", nwin, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_x%0d", i), wxs[i], l3x[i]);
            chk($sformatf("t3_y%0d", i), wys[i], l3y[i]);
            chk($sformatf("t3_centre%0d", i), cen[i], l3c[i]);
        end

        run_frame(3, 100, 100, 10, -1);
        chk("t4_count", nwin, 16);
        chk("t4_stall_held", int'(hold_cnt >= 3), 1);
        chk("t4_ch1_centre", first_w[13], first_w[4] + 100);

        run_frame(4, 50, 50, 100000, -1);
        run_frame(1, 50, 50, 100000, -1);
        run_frame(2, 60, 40, 100000, -1);
        run_frame(3, 70, 60, 100000, -1);

        run_frame(0, 100, 100, 100000, 14);
        rst = 1'b1; iv = 1'b0; ordy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid_after_rst", int'(ov), 0);
        chk("t6_in_ready_after_rst", int'(rdy), 0);
        run_frame(0, 100, 100, 100000, -1);
        pin_case1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
